// File: rtl/instr_fetch.sv
// Instruction fetch unit: small writable program memory plus a PC that holds each
// word on `instr` for the number of cycles its class needs downstream.
module instr_fetch #(
  parameter int INSTR_WIDTH  = 20,
  parameter int ADDR_BITS    = 5,
  parameter int STD_CYCLES   = 3,
  parameter int LOAD_CYCLES  = 4,
  parameter int STORE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   halted
);

  // state  | meaning
  // IDLE   | instr = 0, memory writable, waiting for start
  // PRIME  | word 0 on instr, one extra cycle for downstream RESET->DECODE
  // HOLD   | word held while the counter runs down to 0
  // HALTED | class-00 word reached, instr = 0, left only through reset
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int DEPTH  = 1 << ADDR_BITS;
  localparam int MAX_LS = (LOAD_CYCLES > STORE_CYCLES) ? LOAD_CYCLES : STORE_CYCLES;
  localparam int MAX_N  = (STD_CYCLES > MAX_LS) ? STD_CYCLES : MAX_LS;
  localparam int CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]             state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic [ADDR_BITS-1:0]   pc_inc;

  function automatic logic [CNT_W-1:0] hold_init(input logic [1:0] cls);
    case (cls)
      2'b01:   return CNT_W'(STD_CYCLES - 1);
      2'b10:   return CNT_W'(LOAD_CYCLES - 1);
      default: return CNT_W'(STORE_CYCLES - 1);
    endcase
  endfunction

  assign pc_inc = pc_q + ADDR_BITS'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    fetch_word = '0;

    case (state_q)
      S_IDLE: begin
        mem_we = prog_we;
        if (start) begin
          // a same-cycle write to address 0 must be visible to this fetch
          fetch_word = (prog_we && (prog_addr == '0)) ? prog_data : mem_q[0];
          pc_d       = '0;
          if (fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00) begin
            state_d = S_HALTED;
            instr_d = '0;
          end else begin
            state_d = S_PRIME;
            instr_d = fetch_word;
          end
        end
      end

      S_PRIME: begin
        state_d = S_HOLD;
        cnt_d   = hold_init(instr_q[INSTR_WIDTH-1 -: 2]);
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          fetch_word = mem_q[pc_inc];
          pc_d       = pc_inc;
          if (fetch_word[INSTR_WIDTH-1 -: 2] == 2'b00) begin
            state_d = S_HALTED;
            instr_d = '0;
            cnt_d   = '0;
          end else begin
            instr_d = fetch_word;
            cnt_d   = hold_init(fetch_word[INSTR_WIDTH-1 -: 2]);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_HALTED: begin
        instr_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        instr_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  // program memory survives reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign busy   = (state_q == S_PRIME) || (state_q == S_HOLD);
  assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: per-cycle expected traces are expanded from the program
// contents using the class hold-count rules, then compared on the falling edge.
module tb_instr_fetch;

  localparam int W  = 20;
  localparam int AB = 5;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [W-1:0]  instr;
    logic [AB-1:0] pc;
    logic          busy;
    logic          halted;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          prog_we = 1'b0;
  logic [AB-1:0] prog_addr = '0;
  logic [W-1:0]  prog_data = '0;
  logic [W-1:0]  instr;
  logic [AB-1:0] pc;
  logic          busy;
  logic          halted;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] model_mem [DEPTH];
  obs_t exp_q[$];
  obs_t obs;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  always_comb begin
    obs.instr  = instr;
    obs.pc     = pc;
    obs.busy   = busy;
    obs.halted = halted;
  end

  function automatic int hold_n(input logic [1:0] cls);
    if (cls == 2'b10) return 4;
    return 3;
  endfunction

  // Expand the model memory into one expected observation per cycle after start.
  task automatic build_trace(input int max_len);
    int p;
    bit first;
    bit done;
    logic [W-1:0] w;
    obs_t e;
    exp_q.delete();
    p = 0;
    first = 1'b1;
    done = 1'b0;
    while (!done && exp_q.size() < max_len) begin
      w = model_mem[p];
      if (w[W-1:W-2] == 2'b00) begin
        e.instr = '0; e.pc = AB'(p); e.busy = 1'b0; e.halted = 1'b1;
        repeat (3) exp_q.push_back(e);
        done = 1'b1;
      end else begin
        int n;
        n = hold_n(w[W-1:W-2]) + (first ? 1 : 0);
        first = 1'b0;
        e.instr = w; e.pc = AB'(p); e.busy = 1'b1; e.halted = 1'b0;
        for (int k = 0; k < n && exp_q.size() < max_len; k++) exp_q.push_back(e);
        p = (p + 1) % DEPTH;
      end
    end
  endtask

  task automatic write_word(input logic [AB-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic load_mixed();
    for (int a = 0; a < DEPTH; a++) write_word(AB'(a), 20'h00000);
    write_word(5'd0, 20'h41230);
    write_word(5'd1, 20'h80050);
    write_word(5'd2, 20'hC0050);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== obs_t'(0)) $display("FAIL reset_async got=%h want=%h", obs, obs_t'(0));
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== obs_t'(0)) $display("FAIL reset_held got=%h want=%h", obs, obs_t'(0));
    else n_pass++;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== obs_t'(0)) $display("FAIL reset_idle got=%h want=%h", obs, obs_t'(0));
    else n_pass++;
  endtask

  task automatic test_mixed();
    reset_dut();
    build_trace(14);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_q[i]) $display("FAIL mixed cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    reset_dut();
    pulse_start();
    repeat (9) @(negedge clk);
    n_checks++;
    if (pc !== 5'd2) $display("FAIL midrun_pc got=%0d want=2", pc);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== obs_t'(0)) $display("FAIL midrun_reset got=%h want=%h", obs, obs_t'(0));
    else n_pass++;
    #1 rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (obs !== obs_t'(0)) $display("FAIL midrun_stay_idle got=%h want=%h", obs, obs_t'(0));
      else n_pass++;
    end
  endtask

  task automatic test_write_lockout();
    reset_dut();
    build_trace(14);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      prog_we = 1'b0;
      n_checks++;
      if (obs !== exp_q[i]) $display("FAIL lockout_run1 cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      else n_pass++;
      if (i == 2 || i == 12) begin
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'hFFFFF;
      end
    end
    @(negedge clk);
    prog_we = 1'b0;
    reset_dut();
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_q[i]) $display("FAIL lockout_run2 cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_immediate_halt();
    obs_t e;
    reset_dut();
    write_word(5'd0, 20'h00000);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL halt0_pre busy=%b want=0", busy);
    else n_pass++;
    pulse_start();
    e.instr = '0; e.pc = '0; e.busy = 1'b0; e.halted = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== e) $display("FAIL halt0 cyc=%0d got=%h want=%h", i, obs, e);
      else n_pass++;
      // start and writes must be ignored while halted
      start = (i == 1); prog_we = (i == 1); prog_addr = '0; prog_data = 20'h41111;
    end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    n_checks++;
    if (obs !== e) $display("FAIL halt0_ignore got=%h want=%h", obs, e);
    else n_pass++;
  endtask

  task automatic test_collision();
    reset_dut();
    @(negedge clk);
    start = 1'b1; prog_we = 1'b1; prog_addr = 5'd0; prog_data = 20'h4ABCD;
    model_mem[0] = 20'h4ABCD;
    build_trace(10);
    @(posedge clk);
    #1 start = 1'b0; prog_we = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_q[i]) $display("FAIL collision cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int a = 0; a < DEPTH; a++) write_word(AB'(a), 20'h40000);
    build_trace(1 + 3 * 40);
    pulse_start();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_q[i]) $display("FAIL wrap cyc=%0d got=%h want=%h", i, obs, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int halt_at;
      reset_dut();
      halt_at = $urandom_range(0, 40);
      for (int a = 0; a < DEPTH; a++) begin
        logic [1:0] cls;
        logic [W-1:0] w;
        cls = 2'($urandom_range(1, 3));
        w = {cls, 18'($urandom)};
        if (a == halt_at) w = 20'h00000;
        write_word(AB'(a), w);
      end
      build_trace(140);
      pulse_start();
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp_q[i]) $display("FAIL random it=%0d cyc=%0d got=%h want=%h", it, i, obs, exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    load_mixed();
    test_mixed();
    test_reset_mid_run();
    test_write_lockout();
    test_immediate_halt();
    load_mixed();
    test_collision();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
